// File: rtl/branch_predictor_btb_pkg.sv
// Shared constants for the BTB next-PC predictor: prediction mode encodings.
package branch_predictor_btb_pkg;

    localparam int BP_MODE_STATIC  = 0;
    localparam int BP_MODE_BIMODAL = 1;
    localparam int BP_MODE_BTB     = 2;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter next-value logic, shared by the single update path.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_cur,
    input  logic             i_inc,
    output logic [CTR_W-1:0] o_nxt
);

    always_comb begin
        o_nxt = i_cur;
        if (i_inc && (i_cur != {CTR_W{1'b1}})) begin
            o_nxt = i_cur + CTR_W'(1);
        end else if (!i_inc && (i_cur != {CTR_W{1'b0}})) begin
            o_nxt = i_cur - CTR_W'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry direction counters; combinational lookup,
// trained by execute-stage resolutions, whole-table invalidate on fence.i.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int MODE    = BP_MODE_BIMODAL
) (
    input  logic        clk,
    input  logic        cpu_resetn,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    input  logic        upd_valid,
    input  logic        upd_stall,
    input  logic [31:0] upd_pc,
    input  logic        upd_is_cond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        inval,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] CTR_MAX     = {CTR_W{1'b1}};

    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [29:0]      r_target [ENTRIES];
    logic [CTR_W-1:0] r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic             w_hit;
    logic             w_pred;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_u_hit;
    logic             w_accept;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic             w_unused_lsbs;

    assign w_idx = pc[IDX_W+1:2];
    assign w_tag = pc[31:IDX_W+2];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    always_comb begin
        w_pred = 1'b0;
        if (MODE == BP_MODE_BIMODAL) begin
            w_pred = w_hit && r_ctr[w_idx][CTR_W-1];
        end else if (MODE == BP_MODE_BTB) begin
            w_pred = w_hit;
        end
    end

    assign pred_taken = w_pred;
    assign next_pc    = w_pred ? {r_target[w_idx], 2'b00} : pc + 32'd4;

    // PCs and targets are word aligned, so the two low bits carry no information.
    assign w_unused_lsbs = ^{pc[1:0], upd_pc[1:0], upd_target[1:0]};

    assign w_u_idx  = upd_pc[IDX_W+1:2];
    assign w_u_tag  = upd_pc[31:IDX_W+2];
    assign w_u_hit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    assign w_accept = upd_valid && !upd_stall && !inval;

    sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .i_cur (r_ctr[w_u_idx]),
        .i_inc (upd_taken),
        .o_nxt (w_ctr_nxt)
    );

    always_ff @(posedge clk or negedge cpu_resetn) begin
        if (!cpu_resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_WEAK_NT;
            end
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (inval) begin
            // Targets and counters survive; only the valid bits are dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (w_accept) begin
            perf_branches <= perf_branches + 32'd1;
            if (upd_mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
            if (w_u_hit) begin
                if (upd_is_cond) begin
                    r_ctr[w_u_idx] <= w_ctr_nxt;
                    if (upd_taken) begin
                        r_target[w_u_idx] <= upd_target[31:2];
                    end
                end else begin
                    r_target[w_u_idx] <= upd_target[31:2];
                    r_ctr[w_u_idx]    <= CTR_MAX;
                end
            end else if (upd_taken) begin
                r_valid[w_u_idx]  <= 1'b1;
                r_tag[w_u_idx]    <= w_u_tag;
                r_target[w_u_idx] <= upd_target[31:2];
                r_ctr[w_u_idx]    <= upd_is_cond ? CTR_WEAK_T : CTR_MAX;
            end
        end
    end

endmodule
